// File: rtl/i2c_target_regfile_if.sv
// rtl/i2c_target_regfile_if.sv - pin and local-port bundle for i2c_target_regfile
// Signals:
//   scl_i, sda_i    raw bus pin levels (asynchronous to PCLK)
//   sda_oe          1 = pull SDA low, 0 = release
//   loc_we/addr/wdata/rdata  direct register access from the bridge side
//   wr_strobe/addr/data      committed I2C write (one-cycle pulse)
//   rd_strobe       register loaded for I2C transmit (one-cycle pulse)
//   busy            addressed transaction in progress
// Modports: slave = the target, master = whatever drives the pins and local port.
interface i2c_target_regfile_if #(
  parameter int AW = 4
);
  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic          loc_we;
  logic [AW-1:0] loc_addr;
  logic [7:0]    loc_wdata;
  logic [7:0]    loc_rdata;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          rd_strobe;
  logic          busy;

  modport slave (
    input  scl_i, sda_i, loc_we, loc_addr, loc_wdata,
    output sda_oe, loc_rdata, wr_strobe, wr_addr, wr_data, rd_strobe, busy
  );

  modport master (
    output scl_i, sda_i, loc_we, loc_addr, loc_wdata,
    input  sda_oe, loc_rdata, wr_strobe, wr_addr, wr_data, rd_strobe, busy
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - oversampled I2C target with a byte-wide register file
// Parameters: ADDR (7-bit target address), DEPTH (registers, power of two 2..256).
// Ports:
//   PCLK     system clock, only clock (>= 16x SCL)
//   PRESETn  asynchronous active-low reset
//   bus      i2c_target_regfile_if.slave: pins, local register port, strobes, busy
// Protocol: first written byte sets the register pointer, further bytes write or
// read with pointer auto-increment (wrapping at DEPTH). The pointer survives
// across transactions so a write-pointer + repeated-start read works.
module i2c_target_regfile #(
  parameter logic [6:0] ADDR  = 7'h65,
  parameter int         DEPTH = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  i2c_target_regfile_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WR_BYTE,
    S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  // Input conditioning: two synchroniser stages, then one history stage for edges.
  // Reset to 1 so the idle (pulled-up) bus never looks like an edge.
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  logic scl, sda;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  // SCL must be high on both sides of the SDA edge to count as START/STOP.
  assign start_det = ~sda & sda_d & scl & scl_d;
  assign stop_det  = sda & ~sda_d & scl & scl_d;

  // Protocol state and datapath registers
  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic [AW-1:0] ptr, ptr_n;
  logic          rw, rw_n;
  logic          phase, phase_n;   // second half of an ACK slot / ACK seen in RD_ACK
  logic          sda_oe_q, sda_oe_n;
  logic          busy_q, busy_n;
  logic          wr_strobe_q, rd_strobe_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;

  logic [7:0]    regs [DEPTH];
  logic          commit;
  logic          rd_load;
  logic [7:0]    rx_byte;
  logic [7:0]    rd_word;

  assign rx_byte = {shift[6:0], sda};
  assign rd_word = regs[ptr];

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    rw_n      = rw;
    phase_n   = phase;
    sda_oe_n  = sda_oe_q;
    busy_n    = busy_q;
    commit    = 1'b0;
    rd_load   = 1'b0;

    if (stop_det) begin
      state_n  = S_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      // Any partially shifted byte is simply abandoned here.
      state_n   = S_ADDR;
      bit_cnt_n = 3'd7;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_IGNORE: sda_oe_n = 1'b0;

        S_ADDR: begin
          if (scl_rise) begin
            shift_n = rx_byte;
            if (bit_cnt == 3'd0) begin
              if (rx_byte[7:1] == ADDR) begin
                state_n = S_ADDR_ACK;
                busy_n  = 1'b1;
                rw_n    = rx_byte[0];
                phase_n = 1'b0;
              end else begin
                state_n = S_IGNORE;
                busy_n  = 1'b0;
              end
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end
        end

        // ACK is held from the fall after bit 8 to the fall after bit 9.
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_n = 1'b1;
              phase_n  = 1'b1;
            end else if (rw) begin
              rd_load = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              state_n   = S_PTR;
              bit_cnt_n = 3'd7;
            end
          end
        end

        S_PTR, S_WR_BYTE: begin
          if (scl_rise) begin
            shift_n = rx_byte;
            if (bit_cnt == 3'd0) begin
              state_n = S_WR_ACK;
              phase_n = 1'b0;
              if (state == S_PTR) begin
                ptr_n = rx_byte[AW-1:0];
              end else begin
                commit = 1'b1;
                ptr_n  = ptr + AW'(1);
              end
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end
        end

        S_WR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_n = 1'b1;
              phase_n  = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              state_n   = S_WR_BYTE;
              bit_cnt_n = 3'd7;
            end
          end
        end

        // Bit 7 is already on the line from the load; bit_cnt counts the rest.
        S_RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt != 3'd0) begin
              sda_oe_n  = ~shift[7];
              shift_n   = {shift[6:0], 1'b0};
              bit_cnt_n = bit_cnt - 3'd1;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = S_RD_ACK;
              phase_n  = 1'b0;
            end
          end
        end

        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda) state_n = S_IGNORE;
            else     phase_n = 1'b1;
          end else if (scl_fall && phase) begin
            rd_load = 1'b1;
          end
        end

        default: begin
          state_n  = S_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end

    // Transmit load: first bit goes out on the same edge as the load.
    if (rd_load) begin
      shift_n   = {rd_word[6:0], 1'b0};
      sda_oe_n  = ~rd_word[7];
      bit_cnt_n = 3'd7;
      ptr_n     = ptr + AW'(1);
      state_n   = S_RD_BYTE;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= S_IDLE;
      bit_cnt     <= 3'd7;
      shift       <= 8'h00;
      ptr         <= '0;
      rw          <= 1'b0;
      phase       <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      rd_strobe_q <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      ptr         <= ptr_n;
      rw          <= rw_n;
      phase       <= phase_n;
      sda_oe_q    <= sda_oe_n;
      busy_q      <= busy_n;
      wr_strobe_q <= commit;
      rd_strobe_q <= rd_load;
      if (commit) begin
        wr_addr_q <= ptr;
        wr_data_q <= rx_byte;
      end
    end
  end

  // Register file: the I2C commit is applied last so it wins a same-index collision.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      if (bus.loc_we) regs[bus.loc_addr] <= bus.loc_wdata;
      if (commit)     regs[ptr]          <= rx_byte;
    end
  end

  assign bus.loc_rdata = regs[bus.loc_addr];
  assign bus.sda_oe    = sda_oe_q;
  assign bus.busy      = busy_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_strobe = rd_strobe_q;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - directed self-checking bench for i2c_target_regfile
module tb_i2c_target_regfile;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int Q     = 8;   // PCLK cycles per quarter SCL period

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  logic scl_m   = 1'b1;
  logic sda_m   = 1'b1;

  always #5 PCLK = ~PCLK;

  i2c_target_regfile_if #(.AW(AW)) bus ();

  // Open-drain wired-AND of master and target on SDA
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_target_regfile #(.ADDR(7'h65), .DEPTH(DEPTH)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: register contents, pointer, expected write events
  logic [7:0]  mem [DEPTH];
  int          ptr_m = 0;
  logic [11:0] exp_wr [$];
  int          rd_seen = 0;
  int          rd_exp  = 0;
  bit          sweep_en = 1'b0;
  logic [11:0] wr_e;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Compare process: strobe events against the model, register image during sweeps
  always @(negedge PCLK) begin
    if (PRESETn && bus.wr_strobe) begin
      if (exp_wr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wr_strobe_unexpected: got addr %h data %h expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        wr_e = exp_wr.pop_front();
        check8("wr_addr", {4'h0, bus.wr_addr}, {4'h0, wr_e[11:8]});
        check8("wr_data", bus.wr_data, wr_e[7:0]);
      end
    end
    if (PRESETn && bus.rd_strobe) rd_seen++;
    if (sweep_en) begin
      check8("loc_rdata", bus.loc_rdata, mem[bus.loc_addr]);
      check1("busy_idle", bus.busy, 1'b0);
      check1("sda_oe_idle", bus.sda_oe, 1'b0);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // One SCL period; optional local write aimed at the cycle the DUT sees this rise
  task automatic send_bit(input logic b, input logic coll, output logic s);
    tick(Q); sda_m = b;
    tick(Q); scl_m = 1'b1;
    tick(2);
    if (coll) begin
      bus.loc_addr  = 4'd4;
      bus.loc_wdata = 8'h5A;
      bus.loc_we    = 1'b1;
    end
    tick(1); bus.loc_we = 1'b0;
    tick(Q - 3); s = bus.sda_i;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    tick(Q); sda_m = 1'b1;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_m = 1'b0;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); sda_m = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic coll, output logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], coll && (i == 0), s);
    send_bit(1'b1, 1'b0, nack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    send_bit(nack, 1'b0, s);
  endtask

  task automatic m_addr(input logic [7:0] a, input logic exp_nack);
    logic n;
    write_byte(a, 1'b0, n);
    check1("addr_ack", n, exp_nack);
  endtask

  task automatic m_ptr(input logic [7:0] p);
    logic n;
    write_byte(p, 1'b0, n);
    check1("ptr_ack", n, 1'b0);
    ptr_m = p % DEPTH;
  endtask

  task automatic m_write(input logic [7:0] d, input logic coll);
    logic n;
    exp_wr.push_back({AW'(ptr_m), d});
    mem[ptr_m] = d;
    ptr_m = (ptr_m + 1) % DEPTH;
    write_byte(d, coll, n);
    check1("data_ack", n, 1'b0);
  endtask

  task automatic m_read(input logic nack, output logic [7:0] d);
    logic [7:0] e;
    e = mem[ptr_m];
    ptr_m = (ptr_m + 1) % DEPTH;
    rd_exp++;
    read_byte(nack, d);
    check8("rd_data", d, e);
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    bus.loc_addr  = a;
    bus.loc_wdata = d;
    bus.loc_we    = 1'b1;
    tick(1);
    bus.loc_we    = 1'b0;
    mem[a] = d;
  endtask

  task automatic sweep();
    tick(1);
    sweep_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.loc_addr = AW'(i);
      tick(1);
    end
    sweep_en = 1'b0;
    check8("wr_pending", 8'(exp_wr.size()), 8'h00);
    check8("rd_count", 8'(rd_seen), 8'(rd_exp));
  endtask

  task automatic peek(input logic [3:0] a, input string name, input logic [7:0] exp);
    bus.loc_addr = a;
    tick(1);
    check8(name, bus.loc_rdata, exp);
  endtask

  logic [7:0] d;
  logic       n;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    bus.loc_we    = 1'b0;
    bus.loc_addr  = '0;
    bus.loc_wdata = 8'h00;

    // Reset state
    tick(3);
    check1("rst_sda_oe", bus.sda_oe, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_wr_strobe", bus.wr_strobe, 1'b0);
    check1("rst_rd_strobe", bus.rd_strobe, 1'b0);
    check8("rst_wr_addr", {4'h0, bus.wr_addr}, 8'h00);
    check8("rst_wr_data", bus.wr_data, 8'h00);
    PRESETn = 1'b1;
    sweep();

    // Plain write: ptr 3, data 0x11, 0x22
    i2c_start();
    m_addr(8'hCA, 1'b0);
    check1("busy_addressed", bus.busy, 1'b1);
    m_ptr(8'h03);
    m_write(8'h11, 1'b0);
    m_write(8'h22, 1'b0);
    i2c_stop();
    peek(4'd4, "lit_reg4", 8'h22);
    peek(4'd3, "lit_reg3", 8'h11);
    sweep();

    // Pointer set then repeated-start read of two bytes (ACK, NACK)
    i2c_start();
    m_addr(8'hCA, 1'b0);
    m_ptr(8'h03);
    i2c_start();
    m_addr(8'hCB, 1'b0);
    m_read(1'b0, d);
    check8("lit_rd0", d, 8'h11);
    m_read(1'b1, d);
    check8("lit_rd1", d, 8'h22);
    tick(Q);
    check1("sda_oe_after_nack", bus.sda_oe, 1'b0);
    i2c_stop();
    check8("lit_rd_strobes", 8'(rd_seen), 8'd2);
    sweep();

    // Address mismatch: no ACK, not busy, nothing written
    i2c_start();
    m_addr(8'hA0, 1'b1);
    check1("mismatch_busy", bus.busy, 1'b0);
    write_byte(8'h55, 1'b0, n);
    check1("mismatch_data_nack", n, 1'b1);
    i2c_stop();
    sweep();

    // Pointer wrap and upper pointer bits ignored
    i2c_start();
    m_addr(8'hCA, 1'b0);
    m_ptr(8'h0F);
    m_write(8'hAA, 1'b0);
    m_write(8'hBB, 1'b0);
    i2c_stop();
    peek(4'd15, "lit_reg15", 8'hAA);
    peek(4'd0, "lit_reg0", 8'hBB);
    i2c_start();
    m_addr(8'hCA, 1'b0);
    m_ptr(8'h13);
    m_write(8'h77, 1'b0);
    i2c_stop();
    peek(4'd3, "lit_reg3_via_0x13", 8'h77);
    sweep();

    // Abort after 5 data bits: no commit, pointer stays at 6
    loc_write(4'd6, 8'h66);
    loc_write(4'd7, 8'h67);
    i2c_start();
    m_addr(8'hCA, 1'b0);
    m_ptr(8'h06);
    for (int i = 7; i >= 3; i--) send_bit(1'b0, 1'b0, n);
    i2c_stop();
    check1("abort_busy", bus.busy, 1'b0);
    check1("abort_sda_oe", bus.sda_oe, 1'b0);
    sweep();
    i2c_start();
    m_addr(8'hCB, 1'b0);
    m_read(1'b1, d);
    check8("lit_abort_ptr", d, 8'h66);
    i2c_stop();
    sweep();

    // Local write colliding with an I2C commit to the same register
    i2c_start();
    m_addr(8'hCA, 1'b0);
    m_ptr(8'h04);
    m_write(8'h3C, 1'b1);
    i2c_stop();
    peek(4'd4, "lit_collision", 8'h3C);
    sweep();

    // Reset asserted while the address ACK is on the bus
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hCA >> i) & 8'h01) != 8'h00, 1'b0, n);
    tick(Q); sda_m = 1'b1;
    tick(Q); scl_m = 1'b1;
    tick(Q);
    check1("ack_driven", bus.sda_oe, 1'b1);
    check1("ack_busy", bus.busy, 1'b1);
    #3 PRESETn = 1'b0;
    #1;
    check1("async_rst_sda_oe", bus.sda_oe, 1'b0);
    check1("async_rst_busy", bus.busy, 1'b0);
    check8("async_rst_wr_addr", {4'h0, bus.wr_addr}, 8'h00);
    check8("async_rst_wr_data", bus.wr_data, 8'h00);
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    ptr_m = 0;
    exp_wr.delete();
    sweep();
    tick(2);
    PRESETn = 1'b1;
    tick(Q);
    loc_write(4'd0, 8'h5E);
    loc_write(4'd5, 8'h55);
    i2c_start();
    m_addr(8'hCB, 1'b0);
    m_read(1'b1, d);
    check8("lit_ptr_after_reset", d, 8'h5E);
    i2c_stop();
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
